dmg_timer_n: RTL and testbench
==============================

// Module: dmg_timer_n
// PURPOSE
//  Parametrised programmable timer: free-running prescaler divider feeding an N-bit up-counter with
//  modulo reload and an overflow interrupt pulse. Successor to the single-bit TFFD counter cell.
//  Adds width, selectable prescaler taps, delayed reload and write/overflow arbitration.
//  Sits in the SoC peripheral area beside the interrupt controller; registers are driven by the bus decoder.
// PARAMETERS
//  WIDTH      8    counter, reload-value and write-data width (>=2)
//  DIV_WIDTH  16   prescaler divider width; top 8 bits visible on div
//  TAP0       9    divider bit index used when tap_sel=2'b00 (must be < DIV_WIDTH)
//  TAP1       3    divider bit index for tap_sel=2'b01
//  TAP2       5    divider bit index for tap_sel=2'b10
//  TAP3       7    divider bit index for tap_sel=2'b11
// PORTS
//  clk       in   1          system clock; all state updates on rising edge
//  nres      in   1          asynchronous active-low reset
//  div_rst   in   1          synchronous clear of the whole divider (bus write to DIV)
//  en        in   1          counter enable (TAC bit 2)
//  tap_sel   in   2          prescaler tap select (TAC bits 1:0)
//  load_val  in   WIDTH      modulo/reload value (TMA)
//  wr_cnt    in   1          bus write strobe to counter, one clk
//  wr_data   in   WIDTH      bus write data for counter
//  div       out  8          divider bits [DIV_WIDTH-1 -: 8]
//  cnt       out  WIDTH      counter value (TIMA)
//  irq       out  1          one-clk overflow interrupt pulse
// BEHAVIOUR
//  Reset (nres=0, async): divider=0, cnt=0, irq=0, tick edge register=0, FSM=RUN; outputs valid immediately.
//  Divider: +1 every clk, wraps mod 2^DIV_WIDTH; div_rst=1 forces 0 next clk (no increment that cycle).
//  Tick source t = en & div[TAPsel] using the divider value after this cycle's update; register t_q.
//  Tick = t_q & ~t (falling edge). Consequences, all required:
//   - div_rst while selected tap=1 and en=1 -> one extra tick.
//   - en 1->0 while tap=1 -> one tick. tap_sel change from a bit=1 to a bit=0 -> one tick.
//  Counter FSM (3 states):
//   RUN:     tick -> cnt+1. If cnt was 2^WIDTH-1 -> cnt=0, go PENDING.
//   PENDING: one clk; cnt reads 0. Tick here increments cnt normally (from 0). wr_cnt here -> cnt=wr_data,
//            reload and irq cancelled, go RUN. Else go RELOAD.
//   RELOAD:  cnt=load_val, irq=1 for this clk only, go RUN. wr_cnt in this clk is ignored (load_val wins).
//            load_val written in the same clk is seen (combinational sample).
//  RUN with wr_cnt and tick in the same clk: wr_data wins, tick dropped, no overflow.
//  Latency: tick edge -> cnt update 1 clk; overflow -> irq exactly 2 clks later; irq never >1 clk wide.
//  Reset mid-operation: pending reload and irq discarded; irq deasserts asynchronously.
//  Width rules: all counter arithmetic mod 2^WIDTH; no saturation; load_val=2^WIDTH-1 -> overflow every tick.
// STRUCTURE
//  Package dmg_timer_pkg: tap_sel encodings (TAP_SEL_0..3), FSM state enum (ST_RUN, ST_PENDING, ST_RELOAD).
//  Sub-module dmg_prescaler: divider + tap mux + falling-edge detect; outputs div bus and tick.
//  Top holds counter, FSM, write arbitration and irq register.
// TESTING
//  1 Reset: nres low mid-count -> div=0, cnt=0, irq=0 at once; after release cnt first ticks at clk 2^(TAP+1).
//  2 Rate: tap_sel=01, en=1, load_val=0 -> cnt increments every 16 clk; 0xFF->0x00 at tick 256 -> irq 2 clk later.
//  3 Reload: load_val=0xF0, cnt=0xFF, tick -> cnt 0x00 one clk, then 0xF0 with irq=1 for 1 clk.
//  4 Cancel: overflow then wr_cnt=0x42 in PENDING -> cnt=0x42, no irq; wr_cnt=0x42 in RELOAD -> cnt=load_val, irq=1.
//  5 Glitch ticks: tap bit=1, en=1; pulse div_rst -> cnt+1; separately en 1->0 with bit=1 -> cnt+1.
//  6 Collision: RUN, wr_cnt=0x10 coincident with tick -> cnt=0x10, not 0x11; WIDTH=4 build wraps 0xF->0x0 with irq.

Source files
------------

// File: rtl/dmg_timer_pkg.sv
// dmg_timer_pkg: shared encodings for the programmable timer
//   TAP_SEL_0..3 : prescaler tap select codes (TAC bits 1:0)
//   ST_*         : counter FSM states
package dmg_timer_pkg;
  typedef enum logic [1:0] {TAP_SEL_0 = 2'b00, TAP_SEL_1 = 2'b01, TAP_SEL_2 = 2'b10, TAP_SEL_3 = 2'b11} tap_sel_e;
  typedef enum logic [1:0] {ST_RUN, ST_PENDING, ST_RELOAD} state_e;
endpackage

// File: rtl/dmg_timer_n_if.sv
// dmg_timer_n_if: register-side bus of the timer
//   master : bus decoder side (drives div_rst, en, tap_sel, load_val, wr_cnt, wr_data)
//   slave  : timer side (drives div, cnt, irq)
interface dmg_timer_n_if #(parameter int WIDTH = 8);
  logic             div_rst;
  logic             en;
  logic [1:0]       tap_sel;
  logic [WIDTH-1:0] load_val;
  logic             wr_cnt;
  logic [WIDTH-1:0] wr_data;
  logic [7:0]       div;
  logic [WIDTH-1:0] cnt;
  logic             irq;
  modport master (output div_rst, en, tap_sel, load_val, wr_cnt, wr_data, input div, cnt, irq);
  modport slave (input div_rst, en, tap_sel, load_val, wr_cnt, wr_data, output div, cnt, irq);
endinterface

// File: rtl/dmg_prescaler.sv
// dmg_prescaler: free-running divider, tap mux and falling-edge tick detect
//   clk, nres  : clock, async active-low reset
//   div_rst_i  : sync clear of the divider
//   en_i       : tick enable
//   tap_sel_i  : tap select
//   div_o      : top 8 divider bits
//   tick_o     : one-clk counter increment request
module dmg_prescaler
  import dmg_timer_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int TAP0 = 9,
  parameter int TAP1 = 3,
  parameter int TAP2 = 5,
  parameter int TAP3 = 7
) (
  input  logic       clk,
  input  logic       nres,
  input  logic       div_rst_i,
  input  logic       en_i,
  input  logic [1:0] tap_sel_i,
  output logic [7:0] div_o,
  output logic       tick_o
);
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic t_q, t_d;
  // t_d looks at the post-update divider, so a div_rst or en drop while the
  // tap is high is seen as a falling edge and produces an extra tick
  always_comb begin
    div_d = div_rst_i ? '0 : div_q + DIV_WIDTH'(1);
    t_d = en_i & (tap_sel_i == TAP_SEL_0 ? div_d[TAP0] :
                  tap_sel_i == TAP_SEL_1 ? div_d[TAP1] :
                  tap_sel_i == TAP_SEL_2 ? div_d[TAP2] : div_d[TAP3]);
  end
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      div_q <= '0;
      t_q <= 1'b0;
    end else begin
      div_q <= div_d;
      t_q <= t_d;
    end
  end
  assign tick_o = t_q & ~t_d;
  assign div_o = div_q[DIV_WIDTH-1 -: 8];
endmodule

// File: rtl/dmg_timer_n.sv
// dmg_timer_n: prescaled N-bit timer with delayed modulo reload and overflow irq
//   clk, nres : clock, async active-low reset
//   bus       : slave modport of dmg_timer_n_if (controls in, div/cnt/irq out)
module dmg_timer_n
  import dmg_timer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_WIDTH = 16,
  parameter int TAP0 = 9,
  parameter int TAP1 = 3,
  parameter int TAP2 = 5,
  parameter int TAP3 = 7
) (
  input logic clk,
  input logic nres,
  dmg_timer_n_if.slave bus
);
  state_e st_q, st_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic irq_q;
  logic tick;
  dmg_prescaler #(
    .DIV_WIDTH(DIV_WIDTH), .TAP0(TAP0), .TAP1(TAP1), .TAP2(TAP2), .TAP3(TAP3)
  ) u_pre (
    .clk(clk), .nres(nres), .div_rst_i(bus.div_rst), .en_i(bus.en),
    .tap_sel_i(bus.tap_sel), .div_o(bus.div), .tick_o(tick)
  );
  // PENDING holds the wrapped zero for one clk so a bus write can cancel the
  // reload; RELOAD ignores writes and ticks and always lands on load_val
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    case (st_q)
      ST_RUN: begin
        if (bus.wr_cnt) cnt_d = bus.wr_data;
        else if (tick) begin
          cnt_d = cnt_q + WIDTH'(1);
          st_d = &cnt_q ? ST_PENDING : ST_RUN;
        end
      end
      ST_PENDING: begin
        cnt_d = bus.wr_cnt ? bus.wr_data : bus.load_val;
        st_d = bus.wr_cnt ? ST_RUN : ST_RELOAD;
      end
      default: begin
        cnt_d = bus.load_val;
        st_d = ST_RUN;
      end
    endcase
  end
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      st_q <= ST_RUN;
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      irq_q <= st_d == ST_RELOAD;
    end
  end
  // during RELOAD the counter shows load_val live, so a same-clk TMA write is visible
  assign bus.cnt = st_q == ST_RELOAD ? bus.load_val : cnt_q;
  assign bus.irq = irq_q;
endmodule

// File: tb/tb_dmg_timer_n.sv
// tb_dmg_timer_n: random + directed check of dmg_timer_n (WIDTH 8 and 4) against a reference model
module tb_dmg_timer_n;
  typedef struct {
    int dv;
    bit tp;
    int c;
    int age;
  } mdl_t;
  logic clk = 1'b0;
  logic nres = 1'b1;
  int errs = 0;
  int checks = 0;
  mdl_t m[2];
  dmg_timer_n_if #(.WIDTH(8)) b8 ();
  dmg_timer_n_if #(.WIDTH(4)) b4 ();
  assign b4.div_rst = b8.div_rst;
  assign b4.en = b8.en;
  assign b4.tap_sel = b8.tap_sel;
  assign b4.load_val = b8.load_val[3:0];
  assign b4.wr_cnt = b8.wr_cnt;
  assign b4.wr_data = b8.wr_data[3:0];
  dmg_timer_n #(.WIDTH(8)) u8 (.clk(clk), .nres(nres), .bus(b8));
  dmg_timer_n #(.WIDTH(4)) u4 (.clk(clk), .nres(nres), .bus(b4));
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // age: 0 normal, 1 counter has just wrapped to zero, 2 reload clk (cnt=load_val, irq=1)
  function automatic mdl_t step(mdl_t s, int mask, bit dr, bit e, int ts, int lv, bit w, int wd);
    int taps[4] = '{9, 3, 5, 7};
    bit t;
    bit tk;
    s.dv = dr ? 0 : (s.dv + 1) & 'hFFFF;
    t = e && (((s.dv >> taps[ts]) & 1) == 1);
    tk = s.tp && !t;
    s.tp = t;
    if (s.age == 2) begin
      s.c = lv & mask;
      s.age = 0;
    end else if (s.age == 1) begin
      if (w) begin
        s.c = wd & mask;
        s.age = 0;
      end else s.age = 2;
    end else if (w) s.c = wd & mask;
    else if (tk) begin
      s.c = (s.c + 1) & mask;
      if (s.c == 0) s.age = 1;
    end
    return s;
  endfunction
  task automatic check_all();
    int lv;
    lv = int'(b8.load_val);
    chk("div8", int'(b8.div), m[0].dv >> 8);
    chk("cnt8", int'(b8.cnt), m[0].age == 2 ? lv : m[0].c);
    chk("irq8", int'(b8.irq), int'(m[0].age == 2));
    chk("div4", int'(b4.div), m[1].dv >> 8);
    chk("cnt4", int'(b4.cnt), m[1].age == 2 ? (lv & 15) : m[1].c);
    chk("irq4", int'(b4.irq), int'(m[1].age == 2));
  endtask
  task automatic cyc();
    for (int k = 0; k < 2; k++)
      m[k] = step(m[k], k == 0 ? 255 : 15, b8.div_rst, b8.en, int'(b8.tap_sel),
                  int'(b8.load_val), b8.wr_cnt, int'(b8.wr_data));
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask
  task automatic do_reset();
    #2 nres = 1'b0;
    #1;
    chk("rst_div", int'(b8.div), 0);
    chk("rst_cnt", int'(b8.cnt), 0);
    chk("rst_irq", int'(b8.irq), 0);
    chk("rst_cnt4", int'(b4.cnt), 0);
    for (int k = 0; k < 2; k++) m[k] = '{0, 1'b0, 0, 0};
    @(negedge clk);
    nres = 1'b1;
  endtask
  task automatic wr(int v);
    b8.wr_cnt = 1'b1;
    b8.wr_data = 8'(v);
    cyc();
    b8.wr_cnt = 1'b0;
  endtask
  task automatic wait_cnt(int v, int lim);
    int n = 0;
    while (int'(b8.cnt) != v && n < lim) begin
      cyc();
      n++;
    end
    if (int'(b8.cnt) != v) chk("wait_cnt_timeout", int'(b8.cnt), v);
  endtask
  task automatic wait_dv(int low4);
    int n = 0;
    while ((m[0].dv & 15) != low4 && n < 40) begin
      cyc();
      n++;
    end
    if ((m[0].dv & 15) != low4) chk("wait_dv_timeout", m[0].dv & 15, low4);
  endtask
  initial begin
    int c0;
    int n;
    b8.div_rst = 1'b0;
    b8.en = 1'b1;
    b8.tap_sel = 2'b01;
    b8.load_val = 8'h00;
    b8.wr_cnt = 1'b0;
    b8.wr_data = 8'h00;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 60; i++) cyc();
    // reset mid-count, then first tick on tap 9 lands at clk 1024
    b8.tap_sel = 2'b00;
    do_reset();
    for (int i = 0; i < 1023; i++) cyc();
    chk("first_tick_pre", int'(b8.cnt), 0);
    cyc();
    chk("first_tick", int'(b8.cnt), 1);
    // rate on tap 3: one increment every 16 clk
    b8.tap_sel = 2'b01;
    wr(0);
    wait_cnt(1, 40);
    n = 0;
    while (int'(b8.cnt) == 1 && n < 40) begin
      cyc();
      n++;
    end
    chk("rate16", n, 16);
    // overflow -> zero for one clk -> load_val with irq
    b8.load_val = 8'hF0;
    wr(8'hFF);
    wait_cnt(0, 40);
    chk("ovf_cnt", int'(b8.cnt), 0);
    chk("ovf_irq", int'(b8.irq), 0);
    cyc();
    chk("rld_cnt", int'(b8.cnt), 8'hF0);
    chk("rld_irq", int'(b8.irq), 1);
    chk("rld4_irq", int'(b4.irq), 1);
    chk("rld4_cnt", int'(b4.cnt), 0);
    cyc();
    chk("irq_width", int'(b8.irq), 0);
    // write in PENDING cancels reload and irq
    wr(8'hFF);
    wait_cnt(0, 40);
    wr(8'h42);
    chk("cancel_cnt", int'(b8.cnt), 8'h42);
    chk("cancel_irq", int'(b8.irq), 0);
    cyc();
    chk("cancel_irq2", int'(b8.irq), 0);
    // write in RELOAD is ignored
    wr(8'hFF);
    wait_cnt(0, 40);
    cyc();
    chk("rld_irq_b", int'(b8.irq), 1);
    wr(8'h42);
    chk("rld_wr_ign", int'(b8.cnt), 8'hF0);
    // glitch ticks: div_rst and en drop while tap bit is high
    wr(8'h20);
    wait_dv(9);
    c0 = int'(b8.cnt);
    b8.div_rst = 1'b1;
    cyc();
    b8.div_rst = 1'b0;
    chk("divrst_tick", int'(b8.cnt), c0 + 1);
    wait_dv(9);
    c0 = int'(b8.cnt);
    b8.en = 1'b0;
    cyc();
    b8.en = 1'b1;
    chk("en_tick", int'(b8.cnt), c0 + 1);
    // write coincident with a tick: write wins
    wait_dv(15);
    wr(8'h10);
    chk("collide", int'(b8.cnt), 8'h10);
    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      b8.div_rst = $urandom % 64 == 0;
      b8.en = $urandom % 16 != 0;
      if ($urandom % 64 == 0) b8.tap_sel = 2'($urandom_range(0, 3));
      if ($urandom % 8 == 0 && b8.tap_sel == 2'b00) b8.tap_sel = 2'b01;
      b8.wr_cnt = $urandom % 40 == 0;
      b8.wr_data = $urandom % 2 == 0 ? 8'($urandom) : 8'hF8 | 8'($urandom_range(0, 7));
      if ($urandom % 50 == 0) b8.load_val = $urandom % 3 == 0 ? 8'($urandom) : 8'hF8 | 8'($urandom_range(0, 7));
      if (i == 1500) do_reset();
      else cyc();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
